// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter that puts NUM_CH requesters onto one registered external memory bus.
// Optional bus watchdog: define MEM_ARB_WATCHDOG_EN to compile it in (otherwise ch_err is tied to 0).

module mem_bus_arbiter #(
    parameter int NUM_CH         = 3,
    parameter int AW             = 64,
    parameter int DW             = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     ch_req,
    input  logic [NUM_CH-1:0]     ch_write,
    input  logic [2*NUM_CH-1:0]   ch_width,
    input  logic [AW*NUM_CH-1:0]  ch_addr,
    input  logic [DW*NUM_CH-1:0]  ch_wdata,
    output logic [NUM_CH-1:0]     ch_done,
    output logic [NUM_CH-1:0]     ch_err,
    output logic [DW-1:0]         ch_rdata,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_dout,
    output logic [1:0]            mem_width,
    output logic                  mem_dout_write,
    output logic                  mem_addr_valid,
    input  logic [DW-1:0]         mem_din,
    input  logic                  mem_din_ready
);

    localparam int GW = $clog2(NUM_CH);

    if ((NUM_CH < 2) || (NUM_CH > 8) || (TIMEOUT_CYCLES < 2)) begin : g_param_check
        $error("mem_bus_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [GW-1:0] f_next_ch(input logic [GW-1:0] ch);
        logic [GW-1:0] nxt;
        if (ch == GW'(NUM_CH - 1)) begin
            nxt = '0;
        end else begin
            nxt = ch + GW'(1);
        end
        return nxt;
    endfunction

    state_t          r_state;
    logic [GW-1:0]   r_rr_ptr;
    logic [GW-1:0]   r_grant;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_dout;
    logic [1:0]      r_mem_width;
    logic            r_mem_write;
    logic            r_mem_valid;
    logic [NUM_CH-1:0] r_ch_done;
    logic [DW-1:0]   r_ch_rdata;

    state_t          w_state_nxt;
    logic [GW-1:0]   w_rr_nxt;
    logic [GW-1:0]   w_grant_nxt;
    logic [AW-1:0]   w_mem_addr_nxt;
    logic [DW-1:0]   w_mem_dout_nxt;
    logic [1:0]      w_mem_width_nxt;
    logic            w_mem_write_nxt;
    logic            w_mem_valid_nxt;
    logic [NUM_CH-1:0] w_done_nxt;
    logic [DW-1:0]   w_rdata_nxt;

    logic            w_any_req;
    logic [GW-1:0]   w_pick;
    logic [GW-1:0]   w_idx;

`ifdef MEM_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0]     r_wd_cnt;
    logic              r_timeout;
    logic [NUM_CH-1:0] r_ch_err;
    logic [CW-1:0]     w_wd_cnt_nxt;
    logic              w_timeout_nxt;
    logic [NUM_CH-1:0] w_err_nxt;
`endif

    // Round-robin pick: scan downward so the lowest offset from rr_ptr is kept last.
    always_comb begin
        w_any_req = 1'b0;
        w_pick    = '0;
        w_idx     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_idx = GW'((int'(r_rr_ptr) + i) % NUM_CH);
            if (ch_req[w_idx]) begin
                w_any_req = 1'b1;
                w_pick    = w_idx;
            end else begin
                w_any_req = w_any_req;
            end
        end
    end

    // FSM next-state and next values of every registered output.
    always_comb begin
        w_state_nxt     = r_state;
        w_rr_nxt        = r_rr_ptr;
        w_grant_nxt     = r_grant;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_dout_nxt  = r_mem_dout;
        w_mem_width_nxt = r_mem_width;
        w_mem_write_nxt = r_mem_write;
        w_mem_valid_nxt = r_mem_valid;
        w_done_nxt      = '0;
        w_rdata_nxt     = r_ch_rdata;
`ifdef MEM_ARB_WATCHDOG_EN
        w_wd_cnt_nxt    = r_wd_cnt;
        w_timeout_nxt   = r_timeout;
        w_err_nxt       = '0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt     = ST_BUSY;
                    w_grant_nxt     = w_pick;
                    w_mem_addr_nxt  = ch_addr[int'(w_pick)*AW +: AW];
                    w_mem_dout_nxt  = ch_wdata[int'(w_pick)*DW +: DW];
                    w_mem_width_nxt = ch_width[int'(w_pick)*2 +: 2];
                    w_mem_write_nxt = ch_write[w_pick];
                    w_mem_valid_nxt = 1'b1;
`ifdef MEM_ARB_WATCHDOG_EN
                    w_wd_cnt_nxt    = '0;
                    w_timeout_nxt   = 1'b0;
`endif
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // A ready on the timeout cycle still completes normally.
                if (mem_din_ready && r_mem_valid) begin
                    w_state_nxt     = ST_DONE;
                    w_rdata_nxt     = mem_din;
                    w_mem_valid_nxt = 1'b0;
                    w_mem_write_nxt = 1'b0;
`ifdef MEM_ARB_WATCHDOG_EN
                end else if (r_wd_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt     = ST_DONE;
                    w_rdata_nxt     = '0;
                    w_mem_valid_nxt = 1'b0;
                    w_mem_write_nxt = 1'b0;
                    w_timeout_nxt   = 1'b1;
                end else begin
                    w_wd_cnt_nxt    = r_wd_cnt + CW'(1);
                end
`else
                end else begin
                    w_state_nxt = ST_BUSY;
                end
`endif
            end
            ST_DONE: begin
                w_done_nxt[r_grant] = 1'b1;
`ifdef MEM_ARB_WATCHDOG_EN
                w_err_nxt[r_grant]  = r_timeout;
`endif
                w_rr_nxt            = f_next_ch(r_grant);
                w_state_nxt         = ST_IDLE;
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_mem_valid_nxt = 1'b0;
                w_mem_write_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; async reset drops any pending transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_mem_addr  <= '0;
            r_mem_dout  <= '0;
            r_mem_width <= 2'd0;
            r_mem_write <= 1'b0;
            r_mem_valid <= 1'b0;
            r_ch_done   <= '0;
            r_ch_rdata  <= '0;
`ifdef MEM_ARB_WATCHDOG_EN
            r_wd_cnt    <= '0;
            r_timeout   <= 1'b0;
            r_ch_err    <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_grant     <= w_grant_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_dout  <= w_mem_dout_nxt;
            r_mem_width <= w_mem_width_nxt;
            r_mem_write <= w_mem_write_nxt;
            r_mem_valid <= w_mem_valid_nxt;
            r_ch_done   <= w_done_nxt;
            r_ch_rdata  <= w_rdata_nxt;
`ifdef MEM_ARB_WATCHDOG_EN
            r_wd_cnt    <= w_wd_cnt_nxt;
            r_timeout   <= w_timeout_nxt;
            r_ch_err    <= w_err_nxt;
`endif
        end
    end

    assign ch_done        = r_ch_done;
    assign ch_rdata       = r_ch_rdata;
    assign mem_addr       = r_mem_addr;
    assign mem_dout       = r_mem_dout;
    assign mem_width      = r_mem_width;
    assign mem_dout_write = r_mem_write;
    assign mem_addr_valid = r_mem_valid;
`ifdef MEM_ARB_WATCHDOG_EN
    assign ch_err         = r_ch_err;
`else
    assign ch_err         = '0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: scoreboard of expected completions plus a
// simple memory responder with programmable wait states.

module tb_mem_bus_arbiter;

    localparam int NUM_CH = 3;
    localparam int AW     = 64;
    localparam int DW     = 64;
    localparam int TMO    = 8;
    // Request driven in cycle 0 -> ch_done visible in cycle 3 (the 4th cycle).
    localparam int REQ_TO_DONE = 3;
    // Zero-wait back-to-back: IDLE + BUSY + DONE.
    localparam int B2B = 3;
    localparam logic [DW-1:0] SALT = 64'h5A5A_0000_C3C3_0000;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_CH-1:0]    ch_req;
    logic [NUM_CH-1:0]    ch_write;
    logic [2*NUM_CH-1:0]  ch_width;
    logic [AW*NUM_CH-1:0] ch_addr;
    logic [DW*NUM_CH-1:0] ch_wdata;
    logic [NUM_CH-1:0]    ch_done;
    logic [NUM_CH-1:0]    ch_err;
    logic [DW-1:0]        ch_rdata;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_dout;
    logic [1:0]           mem_width;
    logic                 mem_dout_write;
    logic                 mem_addr_valid;
    logic [DW-1:0]        mem_din;
    logic                 mem_din_ready;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int             ch;
        logic [DW-1:0]  rdata;
        logic           err;
        bit             chk_rd;
    } exp_t;
    exp_t sb[$];

    int            rsp_wait     = 0;
    bit            rsp_override = 1'b0;
    bit            rsp_hang     = 1'b0;
    logic [DW-1:0] rsp_data     = '0;
    int            rsp_cnt      = 0;

    mem_bus_arbiter #(
        .NUM_CH(NUM_CH), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ch_req(ch_req), .ch_write(ch_write), .ch_width(ch_width),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_done(ch_done), .ch_err(ch_err), .ch_rdata(ch_rdata),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_width(mem_width),
        .mem_dout_write(mem_dout_write), .mem_addr_valid(mem_addr_valid),
        .mem_din(mem_din), .mem_din_ready(mem_din_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: ready after rsp_wait stalled cycles of mem_addr_valid.
    always @(negedge clk) begin
        if (mem_addr_valid && !rsp_hang) begin
            if (rsp_cnt == rsp_wait) begin
                mem_din_ready = 1'b1;
                mem_din       = rsp_override ? rsp_data : (mem_addr ^ SALT);
            end else begin
                mem_din_ready = 1'b0;
                mem_din       = ~(mem_addr ^ SALT);
            end
            rsp_cnt = rsp_cnt + 1;
        end else begin
            mem_din_ready = 1'b0;
            mem_din       = 64'hBAD0_BAD0_BAD0_BAD0;
            rsp_cnt       = 0;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "tb_mem_bus_arbiter timed out");
    end

    function automatic logic [NUM_CH-1:0] oh(input int c);
        return NUM_CH'(1) << c;
    endfunction

    task automatic set_ch(input int c, input logic wr, input logic [1:0] w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        ch_write[c]          = wr;
        ch_width[c*2 +: 2]   = w;
        ch_addr[c*AW +: AW]  = a;
        ch_wdata[c*DW +: DW] = d;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        ch_req = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Waits (bounded) for a ch_done pulse; ch = -1 when none arrives.
    task automatic wait_done(input int max_cyc, output int ch, output logic [NUM_CH-1:0] vec,
                             output logic [DW-1:0] rd, output logic err, output int cyc);
        ch = -1; vec = '0; rd = '0; err = 1'b0; cyc = 0;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            if (ch_done != '0) begin
                vec = ch_done;
                rd  = ch_rdata;
                cyc = k;
                for (int b = 0; b < NUM_CH; b++) begin
                    if (ch_done[b]) begin
                        ch  = b;
                        err = ch_err[b];
                    end
                end
                break;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({ch_done, ch_err, ch_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_ch_outputs: got done=%b err=%b rdata=%h, want all 0", ch_done, ch_err, ch_rdata);
        end
        n_checks++;
        if ({mem_addr, mem_dout, mem_width} !== '0) begin
            n_fail++;
            $display("FAIL reset_mem_bus: got addr=%h dout=%h width=%0d, want all 0", mem_addr, mem_dout, mem_width);
        end
        n_checks++;
        if ({mem_addr_valid, mem_dout_write} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mem_ctrl: got valid=%b write=%b, want 0 0", mem_addr_valid, mem_dout_write);
        end
    endtask

    task automatic test_single_read();
        int ch; int cyc; logic [NUM_CH-1:0] vec; logic [DW-1:0] rd; logic err; exp_t e;
        rsp_override = 1'b1; rsp_data = 64'h0000_0000_DEAD_BEEF; rsp_wait = 0;
        set_ch(1, 1'b0, 2'd0, 64'h100, 64'h0);
        ch_req = 3'b010;
        sb.push_back('{ch: 1, rdata: 64'h0000_0000_DEAD_BEEF, err: 1'b0, chk_rd: 1'b1});
        @(negedge clk);
        n_checks++;
        if ({mem_addr_valid, mem_dout_write, mem_addr} !== {1'b1, 1'b0, 64'h100}) begin
            n_fail++;
            $display("FAIL read_bus_req: got valid=%b write=%b addr=%h, want 1 0 100", mem_addr_valid, mem_dout_write, mem_addr);
        end
        wait_done(20, ch, vec, rd, err, cyc);
        ch_req = '0;
        e = sb.pop_front();
        n_checks++;
        if (vec !== oh(e.ch)) begin
            n_fail++;
            $display("FAIL read_done_vec: got %b, want %b", vec, oh(e.ch));
        end
        n_checks++;
        if (rd !== e.rdata) begin
            n_fail++;
            $display("FAIL read_rdata: got %h, want %h", rd, e.rdata);
        end
        n_checks++;
        if (err !== e.err) begin
            n_fail++;
            $display("FAIL read_err: got %b, want %b", err, e.err);
        end
        n_checks++;
        if (cyc + 1 != REQ_TO_DONE) begin
            n_fail++;
            $display("FAIL read_latency: got %0d cycles, want %0d", cyc + 1, REQ_TO_DONE);
        end
        @(negedge clk);
        n_checks++;
        if (ch_done !== '0) begin
            n_fail++;
            $display("FAIL read_done_width: got done=%b one cycle later, want 000", ch_done);
        end
        rsp_override = 1'b0;
    endtask

    task automatic test_round_robin();
        int ch; int cyc; logic [NUM_CH-1:0] vec; logic [DW-1:0] rd; logic err; exp_t e;
        apply_reset();
        rsp_wait = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            set_ch(c, 1'b0, 2'd1, 64'h1000 * (c + 1), 64'h0);
        end
        sb.push_back('{ch: 0, rdata: 64'h1000 ^ SALT, err: 1'b0, chk_rd: 1'b1});
        sb.push_back('{ch: 1, rdata: 64'h2000 ^ SALT, err: 1'b0, chk_rd: 1'b1});
        sb.push_back('{ch: 2, rdata: 64'h3000 ^ SALT, err: 1'b0, chk_rd: 1'b1});
        sb.push_back('{ch: 0, rdata: 64'h1000 ^ SALT, err: 1'b0, chk_rd: 1'b1});
        ch_req = 3'b111;
        for (int t = 0; t < 4; t++) begin
            wait_done(20, ch, vec, rd, err, cyc);
            if (t == 1) ch_req[1] = 1'b0;
            if (t == 2) ch_req[2] = 1'b0;
            if (t == 3) ch_req[0] = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if (vec !== oh(e.ch)) begin
                n_fail++;
                $display("FAIL rr_grant_%0d: got done=%b, want %b", t, vec, oh(e.ch));
            end
            n_checks++;
            if (rd !== e.rdata) begin
                n_fail++;
                $display("FAIL rr_rdata_%0d: got %h, want %h", t, rd, e.rdata);
            end
            if (t > 0) begin
                n_checks++;
                if (cyc != B2B) begin
                    n_fail++;
                    $display("FAIL rr_throughput_%0d: got %0d cycles, want %0d", t, cyc, B2B);
                end
            end
        end
    endtask

    task automatic test_write_wait();
        int wcnt; bit first; bit got; logic [NUM_CH-1:0] vec; logic err; exp_t e;
        rsp_wait = 5;
        set_ch(2, 1'b1, 2'd3, 64'h8, 64'h55AA);
        ch_req = 3'b100;
        sb.push_back('{ch: 2, rdata: '0, err: 1'b0, chk_rd: 1'b0});
        wcnt = 0; first = 1'b1; got = 1'b0; vec = '0; err = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mem_dout_write) begin
                wcnt++;
                if (first) begin
                    first = 1'b0;
                    n_checks++;
                    if ({mem_addr_valid, mem_addr, mem_dout, mem_width} !== {1'b1, 64'h8, 64'h55AA, 2'd3}) begin
                        n_fail++;
                        $display("FAIL write_bus: got valid=%b addr=%h dout=%h width=%0d, want 1 8 55aa 3",
                                 mem_addr_valid, mem_addr, mem_dout, mem_width);
                    end
                end
            end
            if (ch_done != '0) begin
                got = 1'b1; vec = ch_done; err = |ch_err;
                break;
            end
        end
        ch_req = '0;
        e = sb.pop_front();
        n_checks++;
        if (!got || vec !== oh(e.ch)) begin
            n_fail++;
            $display("FAIL write_done: got done=%b seen=%b, want %b", vec, got, oh(e.ch));
        end
        n_checks++;
        if (wcnt != 6) begin
            n_fail++;
            $display("FAIL write_hold: got write high %0d cycles, want 6", wcnt);
        end
        n_checks++;
        if (err !== e.err) begin
            n_fail++;
            $display("FAIL write_err: got %b, want %b", err, e.err);
        end
    endtask

    task automatic test_reset_mid_busy();
        int ch; int cyc; logic [NUM_CH-1:0] vec; logic [DW-1:0] rd; logic err; exp_t e;
        rsp_wait = 0;
        set_ch(1, 1'b0, 2'd0, 64'h200, 64'h0);
        set_ch(2, 1'b0, 2'd0, 64'h300, 64'h0);
        ch_req = 3'b010;
        wait_done(20, ch, vec, rd, err, cyc);
        ch_req = '0;
        n_checks++;
        if (ch != 1) begin
            n_fail++;
            $display("FAIL rst_pre_grant: got ch %0d, want 1", ch);
        end
        rsp_wait = 30;
        ch_req   = 3'b100;
        repeat (3) @(negedge clk);
        ch_req = 3'b110;
        n_checks++;
        if (mem_addr_valid !== 1'b1 || mem_addr !== 64'h300) begin
            n_fail++;
            $display("FAIL rst_busy_state: got valid=%b addr=%h, want 1 300", mem_addr_valid, mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ch_done, ch_err, ch_rdata, mem_addr, mem_dout, mem_width, mem_dout_write, mem_addr_valid} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: got valid=%b addr=%h rdata=%h done=%b, want all 0",
                     mem_addr_valid, mem_addr, ch_rdata, ch_done);
        end
        @(negedge clk);
        rsp_wait = 0;
        rst_n    = 1'b1;
        sb.push_back('{ch: 1, rdata: 64'h200 ^ SALT, err: 1'b0, chk_rd: 1'b1});
        sb.push_back('{ch: 2, rdata: 64'h300 ^ SALT, err: 1'b0, chk_rd: 1'b1});
        @(negedge clk);
        n_checks++;
        if (mem_addr_valid !== 1'b1 || mem_addr !== 64'h200) begin
            n_fail++;
            $display("FAIL rst_regrant: got valid=%b addr=%h, want 1 200", mem_addr_valid, mem_addr);
        end
        for (int t = 0; t < 2; t++) begin
            wait_done(20, ch, vec, rd, err, cyc);
            if (ch >= 0) ch_req[ch] = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if (vec !== oh(e.ch) || rd !== e.rdata) begin
                n_fail++;
                $display("FAIL rst_after_%0d: got done=%b rdata=%h, want %b %h", t, vec, rd, oh(e.ch), e.rdata);
            end
        end
        ch_req = '0;
    endtask

    task automatic test_drop_mid_busy();
        int n_done; logic [NUM_CH-1:0] vec; logic [DW-1:0] rd; exp_t e;
        rsp_wait = 3;
        set_ch(0, 1'b0, 2'd2, 64'h40, 64'h0);
        ch_req = 3'b001;
        sb.push_back('{ch: 0, rdata: 64'h40 ^ SALT, err: 1'b0, chk_rd: 1'b1});
        @(negedge clk);
        ch_req = '0;
        n_checks++;
        if (mem_addr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_busy: got valid=%b, want 1", mem_addr_valid);
        end
        n_done = 0; vec = '0; rd = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ch_done != '0) begin
                n_done++; vec = ch_done; rd = ch_rdata;
            end
        end
        e = sb.pop_front();
        n_checks++;
        if (n_done != 1) begin
            n_fail++;
            $display("FAIL drop_pulses: got %0d done pulses, want 1", n_done);
        end
        n_checks++;
        if (vec !== oh(e.ch) || rd !== e.rdata) begin
            n_fail++;
            $display("FAIL drop_result: got done=%b rdata=%h, want %b %h", vec, rd, oh(e.ch), e.rdata);
        end
    endtask

`ifdef MEM_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        int ch; int cyc; logic [NUM_CH-1:0] vec; logic [DW-1:0] rd; logic err; int nbusy;
        rsp_hang = 1'b1;
        set_ch(0, 1'b0, 2'd0, 64'h80, 64'h0);
        ch_req = 3'b001;
        nbusy = 0; vec = '0; rd = '1; err = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mem_addr_valid) nbusy++;
            if (ch_done != '0) begin
                vec = ch_done; rd = ch_rdata; err = ch_err[0];
                break;
            end
        end
        ch_req   = '0;
        rsp_hang = 1'b0;
        n_checks++;
        if (vec !== 3'b001 || err !== 1'b1 || rd !== '0 || nbusy != TMO) begin
            n_fail++;
            $display("FAIL wd_timeout: got done=%b err=%b rdata=%h busy=%0d, want 001 1 0 %0d", vec, err, rd, nbusy, TMO);
        end
        rsp_wait = 0;
        ch_req   = 3'b001;
        wait_done(20, ch, vec, rd, err, cyc);
        ch_req = '0;
        n_checks++;
        if (vec !== 3'b001 || err !== 1'b0 || rd !== (64'h80 ^ SALT)) begin
            n_fail++;
            $display("FAIL wd_recover: got done=%b err=%b rdata=%h", vec, err, rd);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; ch_req = '0; ch_write = '0; ch_width = '0; ch_addr = '0; ch_wdata = '0;
        mem_din = '0; mem_din_ready = 1'b0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_wait();
        test_reset_mid_busy();
        test_drop_mid_busy();
`ifdef MEM_ARB_WATCHDOG_EN
        test_watchdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Multi-channel arbiter for the unified external memory bus. Each requester is a fixed-width channel, e.g. instruction fetch, data load/store or the JTAG debug port. The block arbitrates round-robin, registers the winning request onto the single external bus, waits for the bus handshake, then returns read data and a one-cycle completion pulse to the winner. It sits between the execution core / debug controller and the off-chip memory pins, and replaces the fixed data-only external path.

## Interface
- NUM_CH, 3: number of requester channels (2..8)
- AW, 64: address width
- DW, 64: data width (bytes = DW/8)
- TIMEOUT_CYCLES, 256: bus watchdog limit (used only when the watchdog is compiled in; ≥2)

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ch_req  in  NUM_CH  per-channel request; held high until the matching ch_done
- ch_write  in  NUM_CH  1 = write, 0 = read
- ch_width  in  2*NUM_CH  access width code per channel (0=DW, 1=32b, 2=16b, 3=8b), forwarded unchanged
- ch_addr  in  AW*NUM_CH  packed addresses, channel i at [i*AW +: AW]
- ch_wdata  in  DW*NUM_CH  packed write data
- ch_done  out  NUM_CH  one-cycle completion pulse to the granted channel
- ch_err  out  NUM_CH  qualifies ch_done; 1 = watchdog timeout
- ch_rdata  out  DW  read data, valid while any ch_done bit is high
- mem_addr  out  AW  registered bus address
- mem_dout  out  DW  registered write data
- mem_width  out  2  registered width code
- mem_dout_write  out  1  write qualifier, valid while mem_addr_valid
- mem_addr_valid  out  1  bus request active
- mem_din  in  DW  read data from the bus
- mem_din_ready  in  1  bus completion, sampled only while mem_addr_valid

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if any ch_req is high, grant the first requesting channel at or after rr_ptr (wrapping modulo NUM_CH). Latch that channel's addr/wdata/write/width into the mem_* registers and go to BUSY.
- BUSY: mem_addr_valid=1. When mem_din_ready=1, capture mem_din into ch_rdata, clear mem_addr_valid and go to DONE.
- DONE: pulse ch_done[g] for one cycle, set rr_ptr = (g+1) mod NUM_CH, return to IDLE.
- Only one channel is granted at a time. Request changes from non-granted channels are ignored until IDLE.
- The granted channel dropping ch_req mid-BUSY has no effect: the bus transaction still completes and ch_done still pulses.
- ch_rdata holds its last value between completions. For writes, ch_rdata is the captured mem_din and is not meaningful.
- Reset (at any time, including mid-BUSY): state=IDLE, rr_ptr=0, mem_addr_valid=0, mem_dout_write=0, mem_addr=0, mem_dout=0, mem_width=0, ch_done=0, ch_err=0, ch_rdata=0. No pending transaction survives reset.

## Timing
- Request high at edge N (IDLE) -> mem_addr_valid high after edge N+1.
- mem_din_ready sampled high at edge M -> ch_done high for the cycle after edge M+1.
- Minimum turnaround is 4 cycles request-to-done with zero-wait memory (mem_din_ready high in the first BUSY cycle).
- IDLE is entered for exactly one cycle between transactions; back-to-back throughput is one transaction per 3 + wait cycles.
- ch_req may fall on the same cycle ch_done is high; a still-high ch_req in the IDLE cycle after DONE is treated as a new request.

## Configuration
- MEM_ARB_WATCHDOG_EN defined: a counter runs in BUSY. If it reaches TIMEOUT_CYCLES without mem_din_ready, the FSM forces DONE with ch_err[g]=1 and ch_rdata=0, mem_addr_valid drops, and the counter clears on every BUSY entry.
- If mem_din_ready and the timeout coincide, mem_din_ready wins (err=0).
- Undefined: no counter; ch_err is tied to 0 and BUSY waits indefinitely.

## Test plan
- Single read, ch1, addr=0x100, mem_din_ready on first BUSY cycle, mem_din=0xDEADBEEF -> ch_done[1] pulses 4 cycles after request, ch_rdata=0xDEADBEEF, ch_err=0.
- All three channels request together from reset -> grants in order 0,1,2; a continued ch0 request then gets its next grant only after 1 and 2 (rr wrap).
- Write from ch2, addr=0x8, wdata=0x55AA, width=3, 5 wait cycles -> mem_addr=0x8, mem_dout=0x55AA, mem_width=3, mem_dout_write=1 held 6 cycles, then ch_done[2].
- rst_n asserted low mid-BUSY -> all outputs 0 immediately (async); after release, a pending ch1 request is re-granted from rr_ptr=0.
- With MEM_ARB_WATCHDOG_EN and TIMEOUT_CYCLES=8, no mem_din_ready -> ch_done[0] with ch_err[0]=1, ch_rdata=0 after 8 BUSY cycles; next request proceeds normally.
- Granted channel drops ch_req after one BUSY cycle -> transaction still completes and ch_done pulses exactly once.
